// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the byte-serial memory arbiter.
//            Holds the access state encoding, the requester identity, the IO
//            address window tag and the access-length decode helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_RUN  = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSB = 1'b1
  } owner_e;

  // addr[17:16] value that marks the memory-mapped IO window
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  // Instruction fetches always move a full word
  localparam logic [2:0] IF_LEN = 3'd4;

  // Byte count for an LSB access; anything other than 1 or 2 is a word
  function automatic logic [2:0] decode_len(input logic [2:0] len);
    case (len)
      3'd1:    decode_len = 3'd1;
      3'd2:    decode_len = 3'd2;
      default: decode_len = 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_grant.sv
// ============================================================================
// Module   : mem_arbiter_grant
// Purpose  : Chooses which requester owns the next memory access.
//            MEM_ARB_RR_EN defined   : round-robin on conflict, remembers the
//                                      last granted requester.
//            MEM_ARB_RR_EN undefined : fixed priority, LSB beats IF, no state.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            accept_i       - an access is being accepted this cycle
//            if_req_i       - qualified fetch request
//            lsb_req_i      - load/store request
//            grant_lsb_o    - 1 = LSB wins, 0 = IF wins
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_grant
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic accept_i,
  input  logic if_req_i,
  input  logic lsb_req_i,
  output logic grant_lsb_o
);

`ifdef MEM_ARB_RR_EN
  // 1 = LSB was granted last; reset state is "IF granted last"
  logic last_lsb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsb_q <= OWNER_IF;
    end else if (accept_i) begin
      last_lsb_q <= grant_lsb_o;
    end
  end

  always_comb begin
    grant_lsb_o = lsb_req_i;
    if (if_req_i && lsb_req_i) begin
      grant_lsb_o = ~last_lsb_q;
    end
  end
`else
  logic unused_grant_inputs;
  assign unused_grant_inputs = &{1'b0, clk, rst_n, accept_i, if_req_i};
  assign grant_lsb_o         = lsb_req_i;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Sole owner of the byte-wide RAM/IO port. Arbitrates instruction
//            fetch (4-byte reads) against the load/store buffer (1/2/4-byte
//            reads/writes), serialises each access one byte per cycle and
//            returns little-endian data with a one-cycle done pulse.
//            Optional round-robin arbitration: define MEM_ARB_RR_EN.
// Ports    : clk, rst_n, rdy          - clock, async reset, global enable
//            rollback                 - flush; aborts fetches only
//            io_buffer_full           - stalls writes into the IO window
//            mem_din/mem_dout/mem_a/mem_wr - byte RAM port (1-cycle read)
//            if_en/if_addr/if_done/if_data - fetch requester
//            lsb_en/lsb_wr/lsb_addr/lsb_len/lsb_w_data/lsb_done/lsb_r_data
//                                     - load/store requester
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              lsb_en,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_len,
  input  logic [DATA_W-1:0] lsb_w_data,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_r_data
);

  mem_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [2:0]        len_q,   len_d;
  logic [2:0]        cnt_q,   cnt_d;
  logic              wr_q,    wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              w_if_req;
  logic              w_grant_lsb;
  logic              w_accept;
  logic [ADDR_W-1:0] w_cur_addr;
  logic              w_io_stall;
  logic              w_if_abort;
  logic [1:0]        w_lane;

  // A flush cancels any fetch request before it can be granted
  assign w_if_req   = if_en & ~rollback;
  assign w_accept   = rdy & (state_q == MEM_ST_IDLE) & (w_if_req | lsb_en);
  assign w_cur_addr = addr_q + ADDR_W'(cnt_q);
  assign w_io_stall = wr_q & io_buffer_full & (w_cur_addr[17:16] == IO_ADDR_HI);
  assign w_if_abort = rollback & (owner_q == OWNER_IF) & (state_q != MEM_ST_IDLE);
  // Read data lags the address by one cycle, so byte k lands in lane k-1
  assign w_lane     = cnt_q[1:0] - 2'd1;

  mem_arbiter_grant u_grant (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (w_accept),
    .if_req_i    (w_if_req),
    .lsb_req_i   (lsb_en),
    .grant_lsb_o (w_grant_lsb)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if_done  = 1'b0;
    lsb_done = 1'b0;

    case (state_q)
      MEM_ST_IDLE: begin
        if (w_accept) begin
          state_d = MEM_ST_RUN;
          cnt_d   = '0;
          rdata_d = '0;
          wdata_d = lsb_w_data;
          if (w_grant_lsb) begin
            owner_d = OWNER_LSB;
            addr_d  = lsb_addr;
            len_d   = decode_len(lsb_len);
            wr_d    = lsb_wr;
          end else begin
            owner_d = OWNER_IF;
            addr_d  = if_addr;
            len_d   = IF_LEN;
            wr_d    = 1'b0;
          end
        end
      end

      MEM_ST_RUN: begin
        if (w_if_abort) begin
          state_d = MEM_ST_IDLE;
        end else if (wr_q) begin
          // A full IO buffer parks the write with the port idle
          if (!w_io_stall) begin
            mem_a    = w_cur_addr;
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr   = rdy;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == len_q - 3'd1) begin
              state_d = MEM_ST_DONE;
            end
          end
        end else begin
          if (cnt_q != len_q) begin
            mem_a = w_cur_addr;
          end
          if (cnt_q != 3'd0) begin
            rdata_d[{w_lane, 3'b000} +: 8] = mem_din;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == len_q) begin
            state_d = MEM_ST_DONE;
          end
        end
      end

      MEM_ST_DONE: begin
        state_d = MEM_ST_IDLE;
        if (rdy && !w_if_abort) begin
          if (owner_q == OWNER_LSB) begin
            lsb_done = 1'b1;
          end else begin
            if_done = 1'b1;
          end
        end
      end

      default: begin
        state_d = MEM_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_ST_IDLE;
      owner_q <= OWNER_IF;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign if_data    = rdata_q;
  assign lsb_r_data = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A byte RAM model with a
//            fixed content pattern answers reads; requester tasks push the
//            expected result into per-requester queues when they drive a
//            request and pop/compare when the done pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int LIMIT = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_en = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_en = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [2:0]  lsb_len = 3'd4;
  logic [31:0] lsb_w_data = '0;
  logic        lsb_done;
  logic [31:0] lsb_r_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_if[$];
  logic [31:0] exp_lsb[$];
  int          done_order[$];

  logic [31:0] wlog_addr[0:63];
  logic [7:0]  wlog_data[0:63];
  int          wlog_n = 0;
  int          lsb_done_cnt = 0;

  mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .rollback       (rollback),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_en          (if_en),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .lsb_en         (lsb_en),
    .lsb_wr         (lsb_wr),
    .lsb_addr       (lsb_addr),
    .lsb_len        (lsb_len),
    .lsb_w_data     (lsb_w_data),
    .lsb_done       (lsb_done),
    .lsb_r_data     (lsb_r_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h11;
      32'h0000_1001: return 8'h22;
      32'h0000_1002: return 8'h33;
      32'h0000_1003: return 8'h44;
      32'h0000_3002: return 8'h80;
      32'h0000_3003: return 8'hFF;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a, input logic [2:0] len);
    int n;
    logic [31:0] w;
    n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) w[8*i +: 8] = init_byte(a + 32'(i));
    end
    return w;
  endfunction

  // RAM: one-cycle read latency, frozen along with the rest of the system when rdy is low
  always @(posedge clk) begin
    if (rdy) mem_din <= init_byte(mem_a);
  end

  always @(negedge clk) begin
    if (mem_wr && wlog_n < 64) begin
      wlog_addr[wlog_n] <= mem_a;
      wlog_data[wlog_n] <= mem_dout;
      wlog_n            <= wlog_n + 1;
    end
    if (lsb_done) lsb_done_cnt <= lsb_done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_lsb(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                        input logic [31:0] wdata, input logic [31:0] exp, input int exp_lat);
    int cyc;
    logic [31:0] e;
    exp_lsb.push_back(exp);
    @(negedge clk);
    lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_w_data = wdata; lsb_en = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!lsb_done && cyc < LIMIT);
    lsb_en = 1'b0;
    e = exp_lsb.pop_front();
    if (!lsb_done) begin
      chk("lsb_timeout", 32'd0, 32'd1);
    end else begin
      done_order.push_back(1);
      if (!wr) chk("lsb_rdata", lsb_r_data, e);
      if (exp_lat >= 0) chk("lsb_latency", 32'(cyc), 32'(exp_lat));
    end
  endtask

  task automatic do_if(input logic [31:0] addr, input logic [31:0] exp, input int exp_lat,
                       input logic expect_abort);
    int cyc;
    logic [31:0] e;
    logic seen;
    if (!expect_abort) exp_if.push_back(exp);
    @(negedge clk);
    if_addr = addr; if_en = 1'b1;
    cyc = 0;
    if (expect_abort) begin
      do begin @(negedge clk); cyc++; end while (!rollback && !if_done && cyc < LIMIT);
      if_en = 1'b0;
      seen = if_done;
      repeat (8) begin @(negedge clk); if (if_done) seen = 1'b1; end
      chk("if_abort_no_done", 32'(seen), 32'd0);
    end else begin
      do begin @(negedge clk); cyc++; end while (!if_done && cyc < LIMIT);
      if_en = 1'b0;
      e = exp_if.pop_front();
      if (!if_done) begin
        chk("if_timeout", 32'd0, 32'd1);
      end else begin
        done_order.push_back(0);
        chk("if_data", if_data, e);
        if (exp_lat >= 0) chk("if_latency", 32'(cyc), 32'(exp_lat));
      end
    end
  endtask

  // One-cycle rollback pulse starting in the RUN cycle that drives byte 2
  task automatic rb_pulse(input int after, input logic [31:0] a_before, input logic [31:0] a_after);
    @(negedge clk);
    repeat (after) @(posedge clk);
    #1 chk("rb_mem_a_before", mem_a, a_before);
    rollback = 1'b1;
    @(posedge clk);
    #1 rollback = 1'b0;
    @(negedge clk);
    chk("rb_mem_a_after", mem_a, a_after);
  endtask

  task automatic chk_store(input logic [31:0] base, input int len, input logic [31:0] data, input int n0);
    chk("st_count", 32'(wlog_n - n0), 32'(len));
    for (int i = 0; i < len; i++) begin
      if (n0 + i < 64) begin
        chk("st_addr", wlog_addr[n0+i], base + 32'(i));
        chk("st_byte", 32'(wlog_data[n0+i]), 32'(data[8*i +: 8]));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int snap;
    int exp_order[3];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_lsb_done", 32'(lsb_done), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_lsb_rdata", lsb_r_data, 32'd0);
    rst_n = 1'b1;

    // Fetch of a known word
    do_if(32'h1000, 32'h4433_2211, 6, 1'b0);

    // Halfword load while a fetch waits behind it
    fork
      do_lsb(1'b0, 32'h3002, 3'd2, 32'd0, 32'h0000_FF80, 4);
      do_if(32'h1000, 32'h4433_2211, 11, 1'b0);
    join

    // Byte store
    n0 = wlog_n;
    do_lsb(1'b1, 32'h2000, 3'd1, 32'hAABB_CCDD, 32'd0, 2);
    chk_store(32'h2000, 1, 32'hAABB_CCDD, n0);

    // Word store into the IO window with the output buffer full for 3 cycles
    n0 = wlog_n;
    io_buffer_full = 1'b1;
    fork
      do_lsb(1'b1, 32'h0003_0000, 3'd4, 32'h1122_3344, 32'd0, 8);
      begin
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("io_stall_wr", 32'(mem_wr), 32'd0);
        chk("io_stall_a", mem_a, 32'd0);
        repeat (3) @(posedge clk);
        #1 io_buffer_full = 1'b0;
      end
    join
    chk_store(32'h0003_0000, 4, 32'h1122_3344, n0);

    // Word store with rdy dropped for 3 cycles mid-access
    n0 = wlog_n;
    fork
      do_lsb(1'b1, 32'h4000, 3'd4, 32'hA1B2_C3D4, 32'd0, 8);
      begin
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        @(negedge clk);
        chk("rdy_low_wr", 32'(mem_wr), 32'd0);
        chk("rdy_low_a", mem_a, 32'h4001);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join
    chk_store(32'h4000, 4, 32'hA1B2_C3D4, n0);

    // Out-of-range length reads a word; fetch wraps past the top of memory
    do_lsb(1'b0, 32'h3000, 3'd7, 32'd0, 32'hFF80_5B5A, 6);
    do_if(32'hFFFF_FFFE, 32'h5B5A_A5A4, 6, 1'b0);

    // Contention: LSB keeps re-requesting while one fetch is pending
    do_if(32'h0500, ram_word(32'h0500, 3'd4), 6, 1'b0);
    done_order.delete();
    fork
      begin
        do_lsb(1'b0, 32'h0600, 3'd4, 32'd0, ram_word(32'h0600, 3'd4), -1);
        do_lsb(1'b0, 32'h0700, 3'd2, 32'd0, ram_word(32'h0700, 3'd2), -1);
      end
      do_if(32'h0800, ram_word(32'h0800, 3'd4), -1, 1'b0);
    join
`ifdef MEM_ARB_RR_EN
    exp_order = '{1, 0, 1};
`else
    exp_order = '{1, 1, 0};
`endif
    chk("order_count", 32'(done_order.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < done_order.size()) chk("order_grant", 32'(done_order[i]), 32'(exp_order[i]));
    end

    // Rollback aborts a fetch but not a load
    fork
      do_if(32'h1000, 32'd0, -1, 1'b1);
      rb_pulse(3, 32'h1002, 32'h0);
    join
    fork
      do_lsb(1'b0, 32'h1000, 3'd4, 32'd0, 32'h4433_2211, 6);
      rb_pulse(3, 32'h1002, 32'h1003);
    join

    // Asynchronous reset in the middle of a load discards it
    @(negedge clk);
    lsb_wr = 1'b0; lsb_addr = 32'h1000; lsb_len = 3'd4; lsb_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_pre_a", mem_a, 32'h1001);
    snap = lsb_done_cnt;
    #2 rst_n = 1'b0;
    #1 chk("arst_mem_a", mem_a, 32'd0);
    lsb_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_done", 32'(lsb_done_cnt - snap), 32'd0);
    do_if(32'h1000, 32'h4433_2211, 6, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
